// File: rtl/mem_wb_pipe_if.sv
// MEM/WB boundary bundle: stall/flush controls, incoming MEM bundle, outgoing WB bundle.
// Latency: none, this is only a signal grouping.
// Backpressure: stall freezes the pipe and flush invalidates it; there is no ready signal.
// Ports: master drives stall/flush/mem_* and observes wb_*/bubble_count; slave is the pipe itself.
interface mem_wb_pipe_if #(
    parameter int WORD   = 32,
    parameter int RWIDTH = 5,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [WORD-1:0]   mem_read_data;
    logic [WORD-1:0]   mem_alu_result;
    logic [RWIDTH-1:0] mem_dest;

    logic              wb_valid;
    logic [CTRL_W-1:0] wb_ctrl;
    logic [WORD-1:0]   wb_read_data;
    logic [WORD-1:0]   wb_alu_result;
    logic [RWIDTH-1:0] wb_dest;
    logic [WORD-1:0]   wb_write_data;
    logic              wb_regwrite_eff;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output stall, flush, mem_valid, mem_ctrl, mem_read_data, mem_alu_result, mem_dest,
        input  wb_valid, wb_ctrl, wb_read_data, wb_alu_result, wb_dest,
        input  wb_write_data, wb_regwrite_eff, bubble_count
    );

    modport slave (
        input  stall, flush, mem_valid, mem_ctrl, mem_read_data, mem_alu_result, mem_dest,
        output wb_valid, wb_ctrl, wb_read_data, wb_alu_result, wb_dest,
        output wb_write_data, wb_regwrite_eff, bubble_count
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB boundary register: DEPTH-stage valid-tagged shift register producing the write-back word.
// Latency: DEPTH cycles from the MEM bundle to the WB outputs, plus one cycle per stalled edge.
// Backpressure: stall holds every stage and freezes the bubble counter; flush clears all stages.
// Ports: clk, rst (synchronous, active-high), bus (mem_wb_pipe_if.slave).
// DEPTH must be in 1..4 and CTRL_W at least 2 (bit0 RegWrite, bit1 MemtoReg).
module mem_wb_pipe #(
    parameter int WORD   = 32,
    parameter int RWIDTH = 5,
    parameter int CTRL_W = 2,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_pipe_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [WORD-1:0]   read_data;
        logic [WORD-1:0]   alu_result;
        logic [RWIDTH-1:0] dest;
    } stage_t;

    stage_t           stg [DEPTH];
    stage_t           load;
    stage_t           last;
    logic [CNT_W-1:0] bubble_cnt;

    // A bubble is stored as all zeroes so downstream never sees stale payload.
    always_comb begin
        load = '0;
        if (bus.mem_valid) begin
            load.valid      = 1'b1;
            load.ctrl       = bus.mem_ctrl;
            load.read_data  = bus.mem_read_data;
            load.alu_result = bus.mem_alu_result;
            load.dest       = bus.mem_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else if (!bus.stall) begin
            stg[0] <= load;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    // Counts empty write-back slots; flush does not block it, stall freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!bus.stall && !last.valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign last = stg[DEPTH-1];

    assign bus.wb_valid        = last.valid;
    assign bus.wb_ctrl         = last.ctrl;
    assign bus.wb_read_data    = last.read_data;
    assign bus.wb_alu_result   = last.alu_result;
    assign bus.wb_dest         = last.dest;
    assign bus.wb_write_data   = last.ctrl[1] ? last.read_data : last.alu_result;
    // Register $0 is hard-wired to zero, so a write to it is never signalled.
    assign bus.wb_regwrite_eff = last.valid & last.ctrl[0] & (last.dest != '0);
    assign bus.bubble_count    = bubble_cnt;
endmodule
